// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encodings and the amount-width helper.
package alu_pkg;

    typedef logic [1:0] alu_mode_t;

    localparam alu_mode_t MODE_ROR = 2'd0;
    localparam alu_mode_t MODE_ROL = 2'd1;
    localparam alu_mode_t MODE_SRL = 2'd2;
    localparam alu_mode_t MODE_SRA = 2'd3;

    // Bits needed to express an amount for a given operand width, never less than 1.
    function automatic int amt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/alu_rotshift_core.sv
// Combinational log2 barrel network: rotate/shift a by normalised amount n.
// sat marks a shift whose requested amount reached WIDTH or more.
module alu_rotshift_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int AMT_W = amt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] n,
    input  logic [1:0]       mode,
    input  logic             sat,
    output logic [WIDTH-1:0] r,
    output logic             carry
);

    // Bit shifted in from the top for right shifts: sign for SRA, zero otherwise.
    logic fill;
    assign fill = (mode == MODE_SRA) && a[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < AMT_W; gi++) begin : g_stage
            localparam int SH = (1 << gi) % WIDTH;
            logic [WIDTH-1:0] din;
            logic [WIDTH-1:0] dout;

            if (gi == 0) begin : g_first
                assign din = a;
            end else begin : g_chain
                assign din = g_stage[gi-1].dout;
            end

            // Each stage moves the word by 2^gi when the matching amount bit is set.
            always_comb begin
                dout = din;
                if (n[gi]) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        case (mode)
                            MODE_ROR: dout[j] = din[(j + SH) % WIDTH];
                            MODE_ROL: dout[j] = din[(j + WIDTH - SH) % WIDTH];
                            default:  dout[j] = ((j + SH) < WIDTH) ? din[(j + SH) % WIDTH] : fill;
                        endcase
                    end
                end
            end
        end
    endgenerate

    assign r = sat ? {WIDTH{fill}} : g_stage[AMT_W-1].dout;

    // Carry is the last bit moved across the edge; no movement means no carry.
    always_comb begin
        carry = 1'b0;
        case (mode)
            MODE_ROR: carry = (n != '0) && r[WIDTH-1];
            MODE_ROL: carry = (n != '0) && r[0];
            default: begin
                if (sat) begin
                    carry = fill;
                end else begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (32'(n) == j + 1) begin
                            carry = a[j];
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_rotshift_pipe.sv
// Two-stage rotate/shift ALU op with valid/ready handshake and full backpressure.
// S1 holds the operand and normalised amount, S2 holds result and flags.
module alu_rotshift_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int AMT_W = amt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_zero,
    output logic             out_carry
);

    logic             s1_v_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [AMT_W-1:0] s1_n_reg;
    logic [1:0]       s1_mode_reg;
    logic             s1_sat_reg;

    logic             s2_v_reg;
    logic [WIDTH-1:0] s2_r_reg;
    logic             s2_zero_reg;
    logic             s2_carry_reg;

    logic             s1_load;
    logic             s2_load;
    logic [AMT_W-1:0] n_next;
    logic             sat_next;
    logic [WIDTH-1:0] core_r;
    logic             core_carry;

    assign s2_load  = !s2_v_reg || out_ready;
    assign s1_load  = !s1_v_reg || s2_load;
    assign in_ready = s1_load;

    // Rotates wrap the amount modulo WIDTH; shifts flag saturation instead.
    always_comb begin
        n_next   = in_amt;
        sat_next = 1'b0;
        if (!in_mode[1]) begin
            n_next = AMT_W'(32'(in_amt) % 32'(WIDTH));
        end else if (32'(in_amt) >= 32'(WIDTH)) begin
            n_next   = '0;
            sat_next = 1'b1;
        end
    end

    // Stage 1: capture an accepted operation; hold contents while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg    <= 1'b0;
            s1_a_reg    <= '0;
            s1_n_reg    <= '0;
            s1_mode_reg <= MODE_ROR;
            s1_sat_reg  <= 1'b0;
        end else if (s1_load) begin
            s1_v_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg    <= in_a;
                s1_n_reg    <= n_next;
                s1_mode_reg <= in_mode;
                s1_sat_reg  <= sat_next;
            end
        end
    end

    alu_rotshift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .a     (s1_a_reg),
        .n     (s1_n_reg),
        .mode  (s1_mode_reg),
        .sat   (s1_sat_reg),
        .r     (core_r),
        .carry (core_carry)
    );

    // Stage 2: register result and flags; output stays frozen until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg     <= 1'b0;
            s2_r_reg     <= '0;
            s2_zero_reg  <= 1'b0;
            s2_carry_reg <= 1'b0;
        end else if (s2_load) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                s2_r_reg     <= core_r;
                s2_zero_reg  <= (core_r == '0);
                s2_carry_reg <= core_carry;
            end
        end
    end

    assign out_valid = s2_v_reg;
    assign out_r     = s2_r_reg;
    assign out_zero  = s2_zero_reg;
    assign out_carry = s2_carry_reg;

endmodule

// File: tb/tb_alu_rotshift_pipe.sv
// Self-checking bench for alu_rotshift_pipe at WIDTH=7: directed vectors,
// throughput, stall, async reset and randomised traffic against a reference model.
module tb_alu_rotshift_pipe;
    import alu_pkg::*;

    localparam int W  = 7;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_r;
    logic          out_zero;
    logic          out_carry;

    alu_rotshift_pipe #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_zero  (out_zero),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           last_out = -1;
    int           n_out = 0;
    bit           strict_lat = 1'b1;
    bit           consec = 1'b0;
    bit           use_exp = 1'b0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_r = '0;
    logic [W-1:0] dir_r = '0;
    logic         dir_c = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: whole-word integer arithmetic following the rotate/shift rules.
    function automatic void ref_op(input logic [W-1:0] a, input logic [AW-1:0] amt,
                                   input logic [1:0] mode, output logic [W-1:0] r,
                                   output logic c);
        int ai, k, n, sa, res, cc;
        ai  = int'(a);
        k   = int'(amt);
        res = 0;
        cc  = 0;
        case (mode)
            MODE_ROR: begin
                n   = k % W;
                res = ((ai >> n) | (ai << (W - n))) & 127;
                cc  = (n == 0) ? 0 : ((res >> (W - 1)) & 1);
            end
            MODE_ROL: begin
                n   = k % W;
                res = ((ai << n) | (ai >> (W - n))) & 127;
                cc  = (n == 0) ? 0 : (res & 1);
            end
            MODE_SRL: begin
                if (k >= W) begin
                    res = 0;
                    cc  = 0;
                end else begin
                    res = ai >> k;
                    cc  = (k == 0) ? 0 : ((ai >> (k - 1)) & 1);
                end
            end
            default: begin
                sa = (ai >= 64) ? ai - 128 : ai;
                if (k >= W) begin
                    res = (sa < 0) ? 127 : 0;
                    cc  = (sa < 0) ? 1 : 0;
                end else begin
                    res = (sa >>> k) & 127;
                    cc  = (k == 0) ? 0 : ((ai >> (k - 1)) & 1);
                end
            end
        endcase
        r = W'(res);
        c = cc[0];
    endfunction

    // One clock cycle: drive at the falling edge, observe 1ns later, predict the
    // transfers that the next rising edge will perform.
    task automatic tick(input logic v, input logic [W-1:0] a, input logic [AW-1:0] amt,
                        input logic [1:0] mode, input logic ordy, output logic acc);
        exp_t         e;
        logic [W-1:0] er;
        logic         ec;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_amt    = amt;
        in_mode   = mode;
        out_ready = ordy;
        #1;
        if (prev_hold) begin
            check_val("hold_valid", 32'(out_valid), 32'(1));
            check_val("hold_r", 32'(out_r), 32'(prev_r));
        end
        prev_hold = out_valid && !out_ready;
        prev_r    = out_r;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check_val("r", 32'(out_r), 32'(e.r));
                check_val("zero", 32'(out_zero), 32'(e.z));
                check_val("carry", 32'(out_carry), 32'(e.c));
                if (strict_lat) check_val("latency", 32'(cyc - e.acc), 32'(2));
                else check_val("latency_min", 32'(cyc - e.acc >= 2), 32'(1));
                if (consec && last_out >= 0) check_val("b2b_gap", 32'(cyc - last_out), 32'(1));
                $display("out cyc=%0d r=%02h zero=%0d carry=%0d lat=%0d",
                         cyc, out_r, out_zero, out_carry, cyc - e.acc);
            end
            n_out++;
            last_out = cyc;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            if (use_exp) begin
                er = dir_r;
                ec = dir_c;
            end else begin
                ref_op(a, amt, mode, er, ec);
            end
            e.r   = er;
            e.z   = (er == '0);
            e.c   = ec;
            e.acc = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic send_dir(input logic [W-1:0] a, input logic [AW-1:0] amt,
                            input logic [1:0] mode, input logic [W-1:0] er, input logic ec);
        logic acc;
        use_exp = 1'b1;
        dir_r   = er;
        dir_c   = ec;
        tick(1'b1, a, amt, mode, 1'b1, acc);
        use_exp = 1'b0;
        check_val("dir_accept", 32'(acc), 32'(1));
        idle(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         acc;
        int           k, n0, guard;
        logic [W-1:0] ta[3];
        logic [AW-1:0] tamt[3];
        logic [1:0]   tmode[3];

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'(0));
        check_val("rst_out_r", 32'(out_r), 32'(0));
        check_val("rst_out_zero", 32'(out_zero), 32'(0));
        check_val("rst_out_carry", 32'(out_carry), 32'(0));
        check_val("rst_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        send_dir(7'h59, 3'd1, MODE_ROR, 7'h6C, 1'b1);
        send_dir(7'h59, 3'd7, MODE_ROR, 7'h59, 1'b0);
        send_dir(7'h59, 3'd2, MODE_ROL, 7'h66, 1'b0);
        send_dir(7'h59, 3'd3, MODE_SRA, 7'h7B, 1'b0);
        send_dir(7'h59, 3'd7, MODE_SRL, 7'h00, 1'b0);
        send_dir(7'h59, 3'd7, MODE_SRA, 7'h7F, 1'b1);
        send_dir(7'h59, 3'd0, MODE_SRL, 7'h59, 1'b0);

        // Back-to-back throughput
        consec   = 1'b1;
        last_out = -1;
        n0       = n_out;
        for (int i = 0; i < 8; i++)
            tick(1'b1, W'($urandom), AW'($urandom), 2'($urandom), 1'b1, acc);
        idle(4);
        consec = 1'b0;
        check_val("b2b_count", 32'(n_out - n0), 32'(8));

        // Stall with out_ready low for 5 cycles
        strict_lat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ta[i]    = W'($urandom);
            tamt[i]  = AW'($urandom);
            tmode[i] = 2'($urandom);
        end
        n0 = n_out;
        k  = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, ta[k], tamt[k], tmode[k], 1'b0, acc);
            if (i < 2) check_val("stall_accept", 32'(acc), 32'(1));
            else check_val("stall_in_ready", 32'(in_ready), 32'(0));
            if (acc && k < 2) k++;
        end
        guard = 0;
        while (k < 3 && guard < 10) begin
            tick(1'b1, ta[k], tamt[k], tmode[k], 1'b1, acc);
            if (acc) k++;
            guard++;
        end
        check_val("stall_all_accepted", 32'(k), 32'(3));
        idle(5);
        check_val("stall_out_count", 32'(n_out - n0), 32'(3));

        // Asynchronous reset with two ops in flight
        strict_lat = 1'b1;
        tick(1'b1, 7'h12, 3'd2, MODE_ROL, 1'b1, acc);
        tick(1'b1, 7'h34, 3'd5, MODE_SRL, 1'b1, acc);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check_val("pre_rst_valid", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'(0));
        check_val("async_rst_r", 32'(out_r), 32'(0));
        sb.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0, '0, 1'b1, acc);
            check_val("no_stale", 32'(out_valid), 32'(0));
        end
        send_dir(7'h59, 3'd1, MODE_ROR, 7'h6C, 1'b1);

        // Randomised traffic with random backpressure
        strict_lat = 1'b0;
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(0, 9) < 7), W'($urandom), AW'($urandom), 2'($urandom),
                 1'($urandom_range(0, 9) < 7), acc);
        idle(6);
        check_val("drain_empty", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
